// File: rtl/mem_pkg.sv
// Shared encodings for the MOV/MFC memory handshake between the CPU datapath and memory.
// The CPU control unit imports this package as well, so encodings live in one place.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_responder_if.sv
// MOV/MFC request bus between the CPU (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 9
);
    logic              mov;
    logic              rw;
    logic [1:0]        size;
    logic              signed_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              mfc;
    logic              err;

    modport master (
        output mov, rw, size, signed_ld, addr, data_in,
        input  data_out, mfc, err
    );

    modport slave (
        input  mov, rw, size, signed_ld, addr, data_in,
        output data_out, mfc, err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: lane_en[3] and bits [31:24] correspond to byte offset 0 of the word.
// Produces write lane enables, replicated write data, the alignment error and the extended read.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        signed_ld,
    input  logic [31:0] rd_word,
    input  logic [31:0] data_in,
    output logic [3:0]  lane_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        err
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = addr_lo[1] ? rd_word[15:0] : rd_word[31:16];
    end

    // Sub-word write data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        lane_en = 4'b0000;
        wr_word = 32'h0000_0000;
        rd_data = 32'h0000_0000;
        err     = 1'b0;
        case (size)
            SIZE_BYTE: begin
                lane_en = 4'b1000 >> addr_lo;
                wr_word = {4{data_in[7:0]}};
                rd_data = {{24{signed_ld & rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                err     = addr_lo[0];
                lane_en = addr_lo[1] ? 4'b0011 : 4'b1100;
                wr_word = {2{data_in[15:0]}};
                rd_data = {{16{signed_ld & rd_half[15]}}, rd_half};
            end
            SIZE_WORD: begin
                err     = (addr_lo != 2'b00);
                lane_en = 4'b1111;
                wr_word = data_in;
                rd_data = rd_word;
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (err) begin
            lane_en = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU's MOV/MFC handshake: byte-addressed big-endian
// storage, one byte/half/word access per request, completed after WAIT_CYCLES wait states.
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_BYTES   = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    mem_responder_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    logic [7:0] mem [MEM_BYTES];

    state_e              state;
    logic [WAIT_W-1:0]   count;
    logic                lat_rw;
    logic [1:0]          lat_size;
    logic                lat_signed;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_data;

    logic                cur_rw;
    logic [1:0]          cur_size;
    logic                cur_signed;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_data;
    logic [ADDR_W-3:0]   word_idx;
    logic [31:0]         rd_word;
    logic [31:0]         wr_word;
    logic [31:0]         rd_data;
    logic [3:0]          lane_en;
    logic                align_err;
    logic                fire;

    // With zero wait states the access happens on the accepting edge, so it must see the live bus.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_rw     = bus.rw;
            cur_size   = bus.size;
            cur_signed = bus.signed_ld;
            cur_addr   = bus.addr;
            cur_data   = bus.data_in;
        end else begin
            cur_rw     = lat_rw;
            cur_size   = lat_size;
            cur_signed = lat_signed;
            cur_addr   = lat_addr;
            cur_data   = lat_data;
        end
    end

    assign word_idx = cur_addr[ADDR_W-1:2];
    assign rd_word  = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

    assign fire = ((state == ST_IDLE) && bus.mov && (WAIT_CYCLES == 0)) ||
                  ((state == ST_BUSY) && (count == WAIT_W'(1)));

    mem_lane_align u_align (
        .size      (cur_size),
        .addr_lo   (cur_addr[1:0]),
        .signed_ld (cur_signed),
        .rd_word   (rd_word),
        .data_in   (cur_data),
        .lane_en   (lane_en),
        .wr_word   (wr_word),
        .rd_data   (rd_data),
        .err       (align_err)
    );

    always_ff @(posedge clk) begin
        if (fire && (cur_rw == RW_WRITE) && !align_err) begin
            if (lane_en[3]) mem[{word_idx, 2'd0}] <= wr_word[31:24];
            if (lane_en[2]) mem[{word_idx, 2'd1}] <= wr_word[23:16];
            if (lane_en[1]) mem[{word_idx, 2'd2}] <= wr_word[15:8];
            if (lane_en[0]) mem[{word_idx, 2'd3}] <= wr_word[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            lat_rw       <= RW_READ;
            lat_size     <= 2'b00;
            lat_signed   <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= 32'h0000_0000;
            bus.mfc      <= 1'b0;
            bus.err      <= 1'b0;
            bus.data_out <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mov) begin
                        lat_rw     <= bus.rw;
                        lat_size   <= bus.size;
                        lat_signed <= bus.signed_ld;
                        lat_addr   <= bus.addr;
                        lat_data   <= bus.data_in;
                        count      <= WAIT_INIT;
                        state      <= (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    count <= count - WAIT_W'(1);
                    if (count == WAIT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.mov) begin
                        state   <= ST_IDLE;
                        bus.mfc <= 1'b0;
                        bus.err <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (fire) begin
                bus.mfc <= 1'b1;
                bus.err <= align_err;
                if ((cur_rw == RW_READ) && !align_err) begin
                    bus.data_out <= rd_data;
                end
            end
        end
    end

endmodule
